// File: rtl/lzc_pkg.sv
// Shared types and the pure count-to-vector decode for lzc_decode.
// Holds the buffer FSM state enum and the lzc_dec decode function.
package lzc_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic              err;
        logic [MAX_W-1:0]  mask;
        logic [MAX_W-1:0]  vec;
    } dec_t;

    // mode 0: count is trailing zeros, mode 1: leading zeros.
    // Bits at or above width stay zero so callers can slice.
    function automatic dec_t lzc_dec(
        input logic [6:0] cnt,
        input logic       empty,
        input logic       mode,
        input int         width
    );
        dec_t r;
        int   c;
        int   top;
        c     = int'(cnt);
        top   = width - 1 - c;
        r.err = empty ? (c != width) : (c >= width);
        r.vec  = '0;
        r.mask = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                if (r.err || empty) begin
                    r.mask[i] = 1'b1;
                end else if (!mode) begin
                    r.vec[i]  = (i == c);
                    r.mask[i] = (i <= c);
                end else begin
                    r.vec[i]  = (i == top);
                    r.mask[i] = (i >= top);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lzc_decode_if.sv
// Token bundle for lzc_decode: input handshake + count, output handshake + decode.
// master drives tokens in and accepts results; slave is the decoder side.
interface lzc_decode_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = $clog2(WIDTH + 1)
);
    logic                 in_valid;
    logic                 in_ready;
    logic [CNT_WIDTH-1:0] in_cnt;
    logic                 in_empty;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     vec;
    logic [WIDTH-1:0]     mask;
    logic                 err;

    modport master (
        output in_valid, in_cnt, in_empty, out_ready,
        input  in_ready, out_valid, vec, mask, err
    );

    modport slave (
        input  in_valid, in_cnt, in_empty, out_ready,
        output in_ready, out_valid, vec, mask, err
    );
endinterface

// File: rtl/lzc_skid_buf.sv
// Two-entry skid buffer: output register plus one skid register, 1-cycle latency.
// Ports: clk_i, rst_i (sync, high), valid_i/ready_o/data_i in, valid_o/ready_i/data_o out.
module lzc_skid_buf
    import lzc_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] data_o
);
    state_e        state_q, state_d;
    logic [DW-1:0] out_q, out_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          ready_q, ready_d;
    logic          in_xfer, out_xfer;

    assign valid_o = (state_q != S_EMPTY);
    assign ready_o = ready_q;
    assign data_o  = out_q;

    always_comb begin
        in_xfer  = valid_i && ready_q;
        out_xfer = valid_o && ready_i;
        state_d  = state_q;
        out_d    = out_q;
        skid_d   = skid_q;
        unique case (state_q)
            S_EMPTY: begin
                if (in_xfer) begin
                    state_d = S_ONE;
                    out_d   = data_i;
                end
            end
            S_ONE: begin
                if (in_xfer && out_xfer) begin
                    out_d = data_i;
                end else if (out_xfer) begin
                    state_d = S_EMPTY;
                end else if (in_xfer) begin
                    state_d = S_TWO;
                    skid_d  = data_i;
                end
            end
            S_TWO: begin
                if (out_xfer) begin
                    state_d = S_ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Registered so ready never follows valid_i combinationally.
        ready_d = (state_d != S_TWO);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end
endmodule

// File: rtl/lzc_decode.sv
// Decodes a zero count (+ empty flag) into canonical vector, fixed-bit mask and error flag.
// Ports: clk_i, rst_i, valid_i/ready_o/cnt_i/empty_i in, valid_o/ready_i/vec_o/mask_o/err_o out.
// Optional LZC_DECODE_ERR_CNT_EN adds err_cnt_o, a saturating count of error tokens sent.
module lzc_decode
    import lzc_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter logic MODE      = 1'b0,
    parameter int   CNT_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 empty_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WIDTH-1:0]     vec_o,
    output logic [WIDTH-1:0]     mask_o,
`ifdef LZC_DECODE_ERR_CNT_EN
    output logic [15:0]          err_cnt_o,
`endif
    output logic                 err_o
);
    localparam int DW = 2 * WIDTH + 1;

    dec_t          dec;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          unused_dec;

    assign dec        = lzc_dec(7'(cnt_i), empty_i, MODE, WIDTH);
    assign din        = {dec.err, dec.mask[WIDTH-1:0], dec.vec[WIDTH-1:0]};
    // Decode is computed at full 64-bit width; upper bits are always zero.
    assign unused_dec = ^dec;

    lzc_skid_buf #(
        .DW(DW)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (din),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (dout)
    );

    assign vec_o  = dout[WIDTH-1:0];
    assign mask_o = dout[2*WIDTH-1:WIDTH];
    assign err_o  = dout[DW-1];

`ifdef LZC_DECODE_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (valid_o && ready_i && err_o && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif
endmodule

// File: tb/tb_lzc_decode.sv
// Randomized + directed bench for lzc_decode, WIDTH=8, both MODE values side by side.
// A queue-based model predicts every output token and the handshake occupancy.
module tb_lzc_decode;

    typedef struct {
        logic [7:0] vec;
        logic [7:0] mask;
        logic       err;
    } tok_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lzc_decode_if #(.WIDTH(8)) bus0 ();
    lzc_decode_if #(.WIDTH(8)) bus1 ();

    int   checks = 0;
    int   errors = 0;
    tok_t q0[$];
    tok_t q1[$];
    bit   rst_last = 1'b1;

`ifdef LZC_DECODE_ERR_CNT_EN
    logic [15:0] ec0, ec1;
    int          merr0 = 0;
    int          merr1 = 0;
`endif

    lzc_decode #(.WIDTH(8), .MODE(1'b0)) u_dut0 (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (bus0.in_valid),
        .ready_o   (bus0.in_ready),
        .cnt_i     (bus0.in_cnt),
        .empty_i   (bus0.in_empty),
        .valid_o   (bus0.out_valid),
        .ready_i   (bus0.out_ready),
        .vec_o     (bus0.vec),
        .mask_o    (bus0.mask),
`ifdef LZC_DECODE_ERR_CNT_EN
        .err_cnt_o (ec0),
`endif
        .err_o     (bus0.err)
    );

    lzc_decode #(.WIDTH(8), .MODE(1'b1)) u_dut1 (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (bus1.in_valid),
        .ready_o   (bus1.in_ready),
        .cnt_i     (bus1.in_cnt),
        .empty_i   (bus1.in_empty),
        .valid_o   (bus1.out_valid),
        .ready_i   (bus1.out_ready),
        .vec_o     (bus1.vec),
        .mask_o    (bus1.mask),
`ifdef LZC_DECODE_ERR_CNT_EN
        .err_cnt_o (ec1),
`endif
        .err_o     (bus1.err)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic tok_t ref_dec(int c, bit e, bit m);
        tok_t t;
        t.err = 1'b0;
        if ((e && c != 8) || (!e && c >= 8)) begin
            t.vec  = 8'h00;
            t.mask = 8'hFF;
            t.err  = 1'b1;
        end else if (e) begin
            t.vec  = 8'h00;
            t.mask = 8'hFF;
        end else if (!m) begin
            t.vec  = 8'(1 << c);
            t.mask = 8'((1 << (c + 1)) - 1);
        end else begin
            t.vec  = 8'(1 << (7 - c));
            t.mask = 8'(255 << (7 - c));
        end
        return t;
    endfunction

    function automatic int tzc(logic [7:0] v);
        int n = 0;
        while (n < 8 && !v[n]) n++;
        return n;
    endfunction

    function automatic int lzcnt(logic [7:0] v);
        int n = 0;
        while (n < 8 && !v[7-n]) n++;
        return n;
    endfunction

    task automatic drive(bit v, int c0, int c1, bit e0, bit e1, bit rdy);
        bus0.in_valid  = v;
        bus1.in_valid  = v;
        bus0.in_cnt    = 4'(c0);
        bus1.in_cnt    = 4'(c1);
        bus0.in_empty  = e0;
        bus1.in_empty  = e1;
        bus0.out_ready = rdy;
        bus1.out_ready = rdy;
    endtask

    task automatic cycle();
        tok_t e;
        if (!rst) begin
            check("ready0", 32'(bus0.in_ready), 32'(!rst_last && q0.size() < 2));
            check("ready1", 32'(bus1.in_ready), 32'(!rst_last && q1.size() < 2));
            check("valid0", 32'(bus0.out_valid), 32'(q0.size() > 0));
            check("valid1", 32'(bus1.out_valid), 32'(q1.size() > 0));
            if (bus0.out_valid && bus0.out_ready && q0.size() > 0) begin
                e = q0.pop_front();
                check("sb_vec0", 32'(bus0.vec), 32'(e.vec));
                check("sb_mask0", 32'(bus0.mask), 32'(e.mask));
                check("sb_err0", 32'(bus0.err), 32'(e.err));
`ifdef LZC_DECODE_ERR_CNT_EN
                if (e.err) merr0++;
`endif
            end
            if (bus1.out_valid && bus1.out_ready && q1.size() > 0) begin
                e = q1.pop_front();
                check("sb_vec1", 32'(bus1.vec), 32'(e.vec));
                check("sb_mask1", 32'(bus1.mask), 32'(e.mask));
                check("sb_err1", 32'(bus1.err), 32'(e.err));
`ifdef LZC_DECODE_ERR_CNT_EN
                if (e.err) merr1++;
`endif
            end
            if (bus0.in_valid && bus0.in_ready)
                q0.push_back(ref_dec(int'(bus0.in_cnt), bus0.in_empty, 1'b0));
            if (bus1.in_valid && bus1.in_ready)
                q1.push_back(ref_dec(int'(bus1.in_cnt), bus1.in_empty, 1'b1));
        end
        rst_last = rst;
        @(posedge clk);
        #1;
        if (rst_last) begin
            q0.delete();
            q1.delete();
`ifdef LZC_DECODE_ERR_CNT_EN
            merr0 = 0;
            merr1 = 0;
`endif
        end
    endtask

    initial begin
        logic [7:0] perm[256];
        logic [7:0] tmp;
        int         j;
        logic [7:0] vv;

        drive(0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        repeat (2) cycle();
        check("rst_valid", 32'(bus0.out_valid), 0);
        check("rst_ready", 32'(bus0.in_ready), 0);
        check("rst_vec", 32'(bus0.vec), 0);
        check("rst_mask", 32'(bus0.mask), 0);
        check("rst_err", 32'(bus0.err), 0);
        check("rst_mask1", 32'(bus1.mask), 0);
        rst = 1'b0;
        cycle();
        check("rdy_after_rst", 32'(bus0.in_ready), 1);

        // cnt 3 non-empty
        drive(1, 3, 3, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 0, 0, 1);
        check("c3_vec0", 32'(bus0.vec), 32'h08);
        check("c3_mask0", 32'(bus0.mask), 32'h0F);
        check("c3_err0", 32'(bus0.err), 0);
        check("c3_vec1", 32'(bus1.vec), 32'h10);
        check("c3_mask1", 32'(bus1.mask), 32'hF0);
        cycle();

        // cnt 0, then the legal empty token
        drive(1, 0, 0, 0, 0, 1);
        cycle();
        drive(1, 8, 8, 1, 1, 1);
        check("c0_vec1", 32'(bus1.vec), 32'h80);
        check("c0_mask1", 32'(bus1.mask), 32'h80);
        check("c0_vec0", 32'(bus0.vec), 32'h01);
        check("c0_mask0", 32'(bus0.mask), 32'h01);
        cycle();
        drive(0, 0, 0, 0, 0, 1);
        check("emp_vec1", 32'(bus1.vec), 32'h00);
        check("emp_mask1", 32'(bus1.mask), 32'hFF);
        check("emp_err1", 32'(bus1.err), 0);
        cycle();

        // inconsistent tokens
        drive(1, 9, 9, 0, 0, 1);
        cycle();
        drive(1, 2, 2, 1, 1, 1);
        check("c9_err0", 32'(bus0.err), 1);
        check("c9_vec0", 32'(bus0.vec), 0);
        check("c9_mask0", 32'(bus0.mask), 32'hFF);
        cycle();
        drive(0, 0, 0, 0, 0, 1);
        check("e2_err1", 32'(bus1.err), 1);
        check("e2_vec1", 32'(bus1.vec), 0);
        check("e2_mask1", 32'(bus1.mask), 32'hFF);
        cycle();
`ifdef LZC_DECODE_ERR_CNT_EN
        check("errcnt0_2", 32'(ec0), 2);
        check("errcnt1_2", 32'(ec1), 2);
`endif

        // backpressure: three tokens offered, two held
        drive(1, 1, 1, 0, 0, 0);
        cycle();
        drive(1, 4, 4, 0, 0, 0);
        cycle();
        drive(1, 6, 6, 0, 0, 0);
        check("bp_ready_two", 32'(bus0.in_ready), 0);
        check("bp_vecA", 32'(bus0.vec), 32'h02);
        cycle();
        check("bp_hold_vec", 32'(bus0.vec), 32'h02);
        check("bp_hold_mask", 32'(bus0.mask), 32'h03);
        check("bp_hold_valid", 32'(bus0.out_valid), 1);
        check("bp_hold_ready", 32'(bus0.in_ready), 0);
        drive(1, 6, 6, 0, 0, 1);
        cycle();
        check("bp_vecB", 32'(bus0.vec), 32'h10);
        cycle();
        check("bp_vecC", 32'(bus0.vec), 32'h40);
        drive(0, 0, 0, 0, 0, 1);
        cycle();
        check("bp_drained", 32'(bus0.out_valid), 0);

        // reset while full
        drive(1, 5, 5, 0, 0, 0);
        cycle();
        drive(1, 7, 7, 0, 0, 0);
        cycle();
        check("rs_two", 32'(bus0.in_ready), 0);
        drive(0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        cycle();
        check("rs_valid", 32'(bus0.out_valid), 0);
        check("rs_ready", 32'(bus0.in_ready), 0);
        rst = 1'b0;
        cycle();
        check("rs_ready_up", 32'(bus0.in_ready), 1);
        check("rs_no_tok", 32'(bus0.out_valid), 0);
`ifdef LZC_DECODE_ERR_CNT_EN
        check("errcnt_rst", 32'(ec0), 0);
`endif

        // loopback over all 256 vectors in shuffled order
        for (int i = 0; i < 256; i++) perm[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j       = int'($urandom_range(0, i));
            tmp     = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            vv = perm[i];
            drive(1, tzc(vv), lzcnt(vv), vv == 0, vv == 0, 1);
            cycle();
            check("lb0", 32'(bus0.vec & bus0.mask), 32'(vv & bus0.mask));
            check("lb1", 32'(bus1.vec & bus1.mask), 32'(vv & bus1.mask));
            check("lb_err", 32'(bus0.err | bus1.err), 0);
        end
        drive(0, 0, 0, 0, 0, 1);
        cycle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) != 0);
            cycle();
        end
        drive(0, 0, 0, 0, 0, 1);
        repeat (4) cycle();
        check("drain_q0", 32'(q0.size()), 0);
        check("drain_q1", 32'(q1.size()), 0);
`ifdef LZC_DECODE_ERR_CNT_EN
        check("errcnt0_end", 32'(ec0), 32'(merr0));
        check("errcnt1_end", 32'(ec1), 32'(merr1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lzc_decode.md
LZC_DECODE -- requirements
Module: lzc_decode

Interface
REQ-001 SHALL have parameter WIDTH, default 8: vector width, legal range 2..64.
REQ-002 SHALL have parameter MODE, default 1'b0: 0 = trailing-zero count, 1 = leading-zero count.
REQ-003 SHALL have parameter CNT_WIDTH, default $clog2(WIDTH+1): dependent parameter, never overridden.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all logic rising-edge.
REQ-005 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port valid_i, input, 1: input token valid.
REQ-007 SHALL have port ready_o, output, 1: block accepts a token.
REQ-008 SHALL have port cnt_i, input, CNT_WIDTH: zero count to decode.
REQ-009 SHALL have port empty_i, input, 1: token marks an all-zero vector.
REQ-010 SHALL have port valid_o, output, 1: output token valid.
REQ-011 SHALL have port ready_i, input, 1: downstream accepts.
REQ-012 SHALL have port vec_o, output, WIDTH: canonical vector for the token.
REQ-013 SHALL have port mask_o, output, WIDTH: bits of vec_o fixed by the count.
REQ-014 SHALL have port err_o, output, 1: token was inconsistent.

Function
REQ-015 SHALL transfer a token when valid && ready on the same edge, in both directions.
REQ-016 SHALL decode a non-empty token with cnt_i < WIDTH as follows: MODE=0 gives vec_o = 1 << cnt_i and mask_o bits [cnt_i:0] set; MODE=1 gives vec_o = 1 << (WIDTH-1-cnt_i) and mask_o bits [WIDTH-1:WIDTH-1-cnt_i] set.
REQ-017 SHALL decode empty_i=1 with cnt_i == WIDTH to vec_o = 0, mask_o = all ones, err_o = 0.
REQ-018 SHALL flag a token with empty_i=0 and cnt_i >= WIDTH, or with empty_i=1 and cnt_i != WIDTH, as err_o = 1, vec_o = 0, mask_o = all ones; the token is still passed downstream.
REQ-019 SHALL have a latency of exactly 1 cycle from an accepted input to valid_o, with all outputs registered and no combinational path from valid_i or cnt_i to any output.
REQ-020 SHALL sustain full throughput of 1 token per cycle while ready_i = 1.
REQ-021 SHALL buffer tokens with a 3-state FSM:
  - EMPTY: no token held.
  - ONE: output register holds a token.
  - TWO: output register plus skid register both hold a token.
REQ-022 SHALL use these FSM transitions:
  - EMPTY to ONE on an input transfer.
  - ONE to EMPTY on an output transfer with no input transfer.
  - ONE to TWO on an input transfer with no output transfer.
  - TWO to ONE on an output transfer; the skid token moves to the output register on that edge.
  - No state change on simultaneous input and output transfers in ONE.
REQ-023 SHALL drive ready_o = 1 in EMPTY and ONE, 0 in TWO, and depend only on registered state.
REQ-024 SHALL hold vec_o, mask_o and err_o stable while valid_o = 1 and ready_i = 0.
REQ-025 SHALL preserve token order; no token is dropped or duplicated.

Reset
REQ-026 SHALL, while rst_i = 1 at a clock edge, force state EMPTY and drive valid_o = 0, vec_o = 0, mask_o = 0, err_o = 0 and ready_o = 0.
REQ-027 SHALL drive ready_o = 1 on the first cycle after rst_i deasserts.
REQ-028 SHALL discard all held tokens on a reset mid-operation, in any state.

Configuration
REQ-029 SHALL, when macro LZC_DECODE_ERR_CNT_EN is defined, add output err_cnt_o[15:0]: reset to 0, increments once per output transfer with err_o = 1, saturates at 16'hFFFF.
REQ-030 SHALL, when LZC_DECODE_ERR_CNT_EN is undefined, omit err_cnt_o and its counter entirely; err_o behaviour is unchanged.

Structure
REQ-031 SHALL place the FSM state enum (S_EMPTY, S_ONE, S_TWO) and a pure decode function (cnt, empty, mode, width to vec, mask, err) in shared package lzc_pkg.
REQ-032 SHALL implement buffering in one sub-module, lzc_skid_buf, a parameterised-width 2-entry skid buffer; lzc_decode instantiates it around the combinational decode.

Verification
REQ-033 SHALL cover: WIDTH=8, MODE=0, token cnt_i=3, empty_i=0, ready_i=1 -> next cycle vec_o=8'h08, mask_o=8'h0F, err_o=0.
REQ-034 SHALL cover: WIDTH=8, MODE=1, cnt_i=0, empty_i=0 -> vec_o=8'h80, mask_o=8'h80; and cnt_i=8, empty_i=1 -> vec_o=8'h00, mask_o=8'hFF, err_o=0.
REQ-035 SHALL cover: cnt_i=9, empty_i=0, and separately cnt_i=2, empty_i=1 -> err_o=1, vec_o=0, mask_o=8'hFF; with macro defined, err_cnt_o=2.
REQ-036 SHALL cover: ready_i=0 with 3 tokens offered back-to-back -> 2 accepted, ready_o=0 in TWO, outputs stable; ready_i=1 -> tokens drain in order on consecutive cycles.
REQ-037 SHALL cover: rst_i=1 asserted in state TWO -> next cycle valid_o=0, ready_o=0; after deassert ready_o=1 and the held tokens never appear.
REQ-038 SHALL cover: loopback with the team's lzc (same WIDTH and MODE) over all 2^8 random vectors v -> decode(lzc(v)) gives vec_o & mask_o == v & mask_o.
